// File: rtl/calc_pkg.sv
`default_nettype none
// calc_pkg: state encoding, key codes, operator codes and limits for calc_control.
// Rev 1.0
package calc_pkg;

   typedef enum logic [2:0] {
      ST_OP1     = 3'd0,
      ST_OP2     = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_RESULT  = 3'd3,
      ST_RELOAD  = 3'd4,
      ST_ERROR   = 3'd5
   } state_t;

   localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
   localparam logic [3:0] KEY_ADD       = 4'd10;
   localparam logic [3:0] KEY_SUB       = 4'd11;
   localparam logic [3:0] KEY_MUL       = 4'd12;
   localparam logic [3:0] KEY_DIV       = 4'd13;
   localparam logic [3:0] KEY_EQUALS    = 4'd14;
   localparam logic [3:0] KEY_CLEAR     = 4'd15;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [1:0] SAVE_NONE  = 2'b00;
   localparam logic [1:0] SAVE_OPND1 = 2'b01;
   localparam logic [1:0] SAVE_OPER  = 2'b10;
   localparam logic [1:0] SAVE_OPND2 = 2'b11;

   localparam logic [2:0] MAX_DIGITS  = 3'd4;
   localparam logic [4:0] ALU_TIMEOUT = 5'd16;

   function automatic logic [1:0] key_to_operator(input logic [3:0] key);
      case (key)
         KEY_SUB: return OP_SUB;
         KEY_MUL: return OP_MUL;
         KEY_DIV: return OP_DIV;
         default: return OP_ADD;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/calc_control.sv
`default_nettype none
// calc_control: keypad-driven FSM sequencing operand/operator storage and ALU requests.
// Rev 1.0
module calc_control
   import calc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   input  logic       alu_done,
   output logic       alu_start,
   output logic [3:0] num,
   output logic [1:0] operator,
   output logic [1:0] save_enable,
   output logic       equ_enable,
   output logic       clear_enable,
   output logic       error,
   output logic [2:0] state_o
);

   state_t     state, state_nx;
   logic [2:0] cnt1, cnt1_nx, cnt2, cnt2_nx;
   logic [4:0] tmo, tmo_nx;
   logic [1:0] op_latch, op_latch_nx;
   logic [3:0] held, held_nx;

   logic       start_nx, equ_nx, clr_nx, err_nx;
   logic [3:0] num_nx;
   logic [1:0] oper_nx, save_nx;

   logic accept, is_digit, is_oper;

   assign key_ready = (state == ST_OP1) || (state == ST_OP2) ||
                      (state == ST_RESULT) || (state == ST_ERROR);
   assign state_o   = state;
   assign accept    = key_valid && key_ready;
   assign is_digit  = key_code <= KEY_DIGIT_MAX;
   assign is_oper   = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);

   always_comb begin
      state_nx    = state;
      cnt1_nx     = cnt1;
      cnt2_nx     = cnt2;
      tmo_nx      = tmo;
      op_latch_nx = op_latch;
      held_nx     = held;
      start_nx    = 1'b0;
      num_nx      = 4'd0;
      oper_nx     = OP_ADD;
      save_nx     = SAVE_NONE;
      equ_nx      = 1'b0;
      clr_nx      = 1'b0;
      err_nx      = error;

      if (accept && key_code == KEY_CLEAR) begin
         clr_nx      = 1'b1;
         cnt1_nx     = 3'd0;
         cnt2_nx     = 3'd0;
         op_latch_nx = OP_ADD;
         err_nx      = 1'b0;
         state_nx    = ST_OP1;
      end else begin
         case (state)
            ST_OP1: begin
               if (accept && is_digit) begin
                  if (cnt1 < MAX_DIGITS) begin
                     save_nx = SAVE_OPND1;
                     num_nx  = key_code;
                     cnt1_nx = cnt1 + 3'd1;
                  end
               end else if (accept && is_oper && cnt1 != 3'd0) begin
                  save_nx     = SAVE_OPER;
                  oper_nx     = key_to_operator(key_code);
                  op_latch_nx = key_to_operator(key_code);
                  state_nx    = ST_OP2;
               end
            end
            ST_OP2: begin
               if (accept && is_digit) begin
                  if (cnt2 < MAX_DIGITS) begin
                     save_nx = SAVE_OPND2;
                     num_nx  = key_code;
                     cnt2_nx = cnt2 + 3'd1;
                  end
               end else if (accept && key_code == KEY_EQUALS && cnt2 != 3'd0) begin
                  start_nx = 1'b1;
                  oper_nx  = op_latch;
                  tmo_nx   = ALU_TIMEOUT;
                  state_nx = ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               // a result arriving on the last allowed cycle still counts
               if (alu_done) begin
                  save_nx  = SAVE_OPND1;
                  equ_nx   = 1'b1;
                  state_nx = ST_RESULT;
               end else begin
                  tmo_nx = tmo - 5'd1;
                  if (tmo == 5'd1) begin
                     err_nx   = 1'b1;
                     state_nx = ST_ERROR;
                  end
               end
            end
            ST_RESULT: begin
               if (accept && is_digit) begin
                  clr_nx   = 1'b1;
                  held_nx  = key_code;
                  state_nx = ST_RELOAD;
               end
            end
            ST_RELOAD: begin
               // the digit that ended RESULT becomes the first digit of a new operand1
               save_nx  = SAVE_OPND1;
               num_nx   = held;
               cnt1_nx  = 3'd1;
               cnt2_nx  = 3'd0;
               state_nx = ST_OP1;
            end
            ST_ERROR: begin
            end
            default: state_nx = ST_OP1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_OP1;
         cnt1         <= 3'd0;
         cnt2         <= 3'd0;
         tmo          <= 5'd0;
         op_latch     <= OP_ADD;
         held         <= 4'd0;
         alu_start    <= 1'b0;
         num          <= 4'd0;
         operator     <= OP_ADD;
         save_enable  <= SAVE_NONE;
         equ_enable   <= 1'b0;
         clear_enable <= 1'b0;
         error        <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt1         <= cnt1_nx;
         cnt2         <= cnt2_nx;
         tmo          <= tmo_nx;
         op_latch     <= op_latch_nx;
         held         <= held_nx;
         alu_start    <= start_nx;
         num          <= num_nx;
         operator     <= oper_nx;
         save_enable  <= save_nx;
         equ_enable   <= equ_nx;
         clear_enable <= clr_nx;
         error        <= err_nx;
      end
   end

endmodule
`default_nettype wire
